link_capture: RTL and testbench

LINK_CAPTURE -- requirements
Module: link_capture

---
 rtl/link_capture.sv | 201 ++++++++++++++++++++
 tb/tb_link_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/link_capture.sv
// link_capture
//   Receives words from an asynchronous dual-rail delay-insensitive link,
//   synchronizes every rail into the clk domain, decodes the words, and
//   buffers them in a small FIFO. The sender is acknowledged on ack_o.
//
//   ENC = "TP": two-phase signalling. One rail of each bit toggles per word,
//               and ack_o toggles once per accepted word.
//   ENC = "FP": four-phase return-to-zero signalling. A data phase is followed
//               by an all-zero spacer. ack_o rises after capture and falls
//               after the spacer.
//
// Ports
//   clk        sole clock, rising-edge
//   rst        synchronous reset, active-low
//   in         dual-rail link [bit][rail]; rail 1 encodes 1, rail 0 encodes 0
//   ack_o      registered link acknowledge
//   out_data   FIFO head word
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts head (pop on out_valid && out_ready)
//   fifo_level FIFO occupancy
//   word_cnt   words captured since reset (wrapping)
//   stall      complete word waiting on a full FIFO
//   proto_err  sticky protocol-violation flag
module link_capture #(
  parameter         ENC         = "TP",
  parameter int     WIDTH       = 8,
  parameter int     DEPTH       = 4,
  parameter int     ACK_DELAY   = 2,
  parameter int     SYNC_STAGES = 2,
  localparam int    RAIL_NUM    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]    in,
  output logic                              ack_o,
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(DEPTH):0]            fifo_level,
  output logic [31:0]                       word_cnt,
  output logic                              stall,
  output logic                              proto_err
);

  localparam bit IS_FP = (ENC == "FP");
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = $clog2(ACK_DELAY + 1);

  typedef enum logic [1:0] {WAIT, DELAY, RTZ, RDELAY} state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic                            ack_nxt;
  logic                            push, pop, full, space, in_load;
  logic [WIDTH-1:0][RAIL_NUM-1:0]  sync_p [SYNC_STAGES];
  logic [WIDTH-1:0][RAIL_NUM-1:0]  sin;
  logic [WIDTH-1:0][RAIL_NUM-1:0]  in_state;
  logic [RAIL_NUM-1:0]             delta;
  logic [WIDTH-1:0]                bit_ok, bit_err, word_val;
  logic                            word_complete, any_err, spacer, err_set;
  logic [WIDTH-1:0]                mem [DEPTH];
  logic [AW-1:0]                   wr_ptr, rd_ptr;

  // Stage p0..pN: rail synchronizer chain
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
    end else begin
      sync_p[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign sin = sync_p[SYNC_STAGES-1];

  // Decode: in two-phase mode a bit is judged on what changed since the last
  // acknowledged word; in four-phase mode on the rail levels themselves.
  // An erroneous bit (both rails) is never "ok", so it blocks completion.
  always_comb begin
    bit_ok   = '0;
    bit_err  = '0;
    word_val = '0;
    delta    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      delta       = IS_FP ? sin[i] : (sin[i] ^ in_state[i]);
      bit_ok[i]   = (delta == 2'b01) || (delta == 2'b10);
      bit_err[i]  = (delta == 2'b11);
      word_val[i] = delta[1];
    end
  end

  assign word_complete = &bit_ok;
  assign any_err       = |bit_err;
  assign spacer        = (sin == '0);

  // FIFO status; a pop in the same cycle frees the slot a push needs
  assign full      = (fifo_level == LW'(DEPTH));
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign space     = !full || pop;
  assign out_data  = mem[rd_ptr];

  // Handshake FSM: next state and outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = ack_o;
    push      = 1'b0;
    in_load   = 1'b0;
    stall     = 1'b0;
    case (state)
      WAIT: begin
        if (word_complete) begin
          if (space) begin
            push      = 1'b1;
            cnt_nxt   = CNT_W'(ACK_DELAY - 1);
            state_nxt = DELAY;
          end else begin
            stall = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          if (IS_FP) begin
            ack_nxt   = 1'b1;
            state_nxt = RTZ;
          end else begin
            ack_nxt   = ~ack_o;
            in_load   = 1'b1;
            state_nxt = WAIT;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RTZ: begin
        if (spacer) begin
          cnt_nxt   = CNT_W'(ACK_DELAY - 1);
          state_nxt = RDELAY;
        end
      end
      RDELAY: begin
        if (cnt == '0) begin
          ack_nxt   = 1'b0;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Two-phase violations only count while a word is being judged against
  // in_state; four-phase violations count at any time.
  assign err_set = any_err && (IS_FP || (state == WAIT) || (state == DELAY));

  // Handshake FSM: state register and control
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT;
      cnt       <= '0;
      ack_o     <= 1'b0;
      in_state  <= '0;
      word_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_o <= ack_nxt;
      if (in_load) in_state  <= sin;
      if (push)    word_cnt  <= word_cnt + 32'd1;
      if (err_set) proto_err <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_val;
  end

  // FIFO pointers and level
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_link_capture.sv
// tb_link_capture
//   Directed bench for link_capture: a two-phase instance (WIDTH=4, DEPTH=2,
//   ACK_DELAY=2) and a four-phase instance (WIDTH=2, DEPTH=4, ACK_DELAY=2).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_link_capture;

  logic clk;
  logic rst;

  logic [3:0][1:0] tp_in;
  logic            tp_ack, tp_valid, tp_ready, tp_stall, tp_err;
  logic [3:0]      tp_data;
  logic [1:0]      tp_level;
  logic [31:0]     tp_cnt;

  logic [1:0][1:0] fp_in;
  logic            fp_ack, fp_valid, fp_ready, fp_stall, fp_err;
  logic [1:0]      fp_data;
  logic [2:0]      fp_level;
  logic [31:0]     fp_cnt;

  int checks;
  int failures;

  link_capture #(.ENC("TP"), .WIDTH(4), .DEPTH(2), .ACK_DELAY(2), .SYNC_STAGES(2)) u_tp (
    .clk(clk), .rst(rst), .in(tp_in), .ack_o(tp_ack), .out_data(tp_data),
    .out_valid(tp_valid), .out_ready(tp_ready), .fifo_level(tp_level),
    .word_cnt(tp_cnt), .stall(tp_stall), .proto_err(tp_err)
  );

  link_capture #(.ENC("FP"), .WIDTH(2), .DEPTH(4), .ACK_DELAY(2), .SYNC_STAGES(2)) u_fp (
    .clk(clk), .rst(rst), .in(fp_in), .ack_o(fp_ack), .out_data(fp_data),
    .out_valid(fp_valid), .out_ready(fp_ready), .fifo_level(fp_level),
    .word_cnt(fp_cnt), .stall(fp_stall), .proto_err(fp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two-phase word: toggle rail 1 for a one bit, rail 0 for a zero bit
  task automatic send_tp(input logic [3:0] val);
    for (int i = 0; i < 4; i++) begin
      if (val[i]) tp_in[i][1] = ~tp_in[i][1];
      else        tp_in[i][0] = ~tp_in[i][0];
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    tp_in    = '0;
    fp_in    = '0;
    tp_ready = 1'b0;
    fp_ready = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tp_ack !== 1'b0)    begin failures++; $display("FAIL rst_tp_ack got=%b exp=0", tp_ack); end
    checks++; if (tp_valid !== 1'b0)  begin failures++; $display("FAIL rst_tp_valid got=%b exp=0", tp_valid); end
    checks++; if (tp_level !== 2'd0)  begin failures++; $display("FAIL rst_tp_level got=%0d exp=0", tp_level); end
    checks++; if (tp_cnt !== 32'd0)   begin failures++; $display("FAIL rst_tp_cnt got=%0d exp=0", tp_cnt); end
    checks++; if (tp_stall !== 1'b0)  begin failures++; $display("FAIL rst_tp_stall got=%b exp=0", tp_stall); end
    checks++; if (tp_err !== 1'b0)    begin failures++; $display("FAIL rst_tp_err got=%b exp=0", tp_err); end
    checks++; if (fp_ack !== 1'b0)    begin failures++; $display("FAIL rst_fp_ack got=%b exp=0", fp_ack); end
    checks++; if (fp_level !== 3'd0)  begin failures++; $display("FAIL rst_fp_level got=%0d exp=0", fp_level); end
    checks++; if (fp_err !== 1'b0)    begin failures++; $display("FAIL rst_fp_err got=%b exp=0", fp_err); end
  endtask

  task automatic test_tp_words();
    send_tp(4'hA);
    tick(2);
    checks++; if (tp_cnt !== 32'd0)  begin failures++; $display("FAIL tp_early_cnt got=%0d exp=0", tp_cnt); end
    tick(1);
    checks++; if (tp_cnt !== 32'd1)  begin failures++; $display("FAIL tp_cnt1 got=%0d exp=1", tp_cnt); end
    checks++; if (tp_level !== 2'd1) begin failures++; $display("FAIL tp_level1 got=%0d exp=1", tp_level); end
    checks++; if (tp_data !== 4'hA)  begin failures++; $display("FAIL tp_data1 got=%h exp=a", tp_data); end
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL tp_ack_cap got=%b exp=0", tp_ack); end
    tick(1);
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL tp_ack_d1 got=%b exp=0", tp_ack); end
    tick(1);
    checks++; if (tp_ack !== 1'b1)   begin failures++; $display("FAIL tp_ack_d2 got=%b exp=1", tp_ack); end

    send_tp(4'h5);
    tick(3);
    checks++; if (tp_cnt !== 32'd2)  begin failures++; $display("FAIL tp_cnt2 got=%0d exp=2", tp_cnt); end
    checks++; if (tp_level !== 2'd2) begin failures++; $display("FAIL tp_level2 got=%0d exp=2", tp_level); end
    tick(1);
    checks++; if (tp_ack !== 1'b1)   begin failures++; $display("FAIL tp_ack2_d1 got=%b exp=1", tp_ack); end
    tick(1);
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL tp_ack2_d2 got=%b exp=0", tp_ack); end
    checks++; if (tp_data !== 4'hA)  begin failures++; $display("FAIL tp_head_hold got=%h exp=a", tp_data); end
  endtask

  task automatic test_back_to_back();
    send_tp(4'h3);
    tick(6);
    checks++; if (tp_stall !== 1'b1) begin failures++; $display("FAIL bp_stall got=%b exp=1", tp_stall); end
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL bp_no_ack got=%b exp=0", tp_ack); end
    checks++; if (tp_cnt !== 32'd2)  begin failures++; $display("FAIL bp_cnt got=%0d exp=2", tp_cnt); end
    checks++; if (tp_level !== 2'd2) begin failures++; $display("FAIL bp_level got=%0d exp=2", tp_level); end
    checks++; if (tp_data !== 4'hA)  begin failures++; $display("FAIL bp_head got=%h exp=a", tp_data); end
    tp_ready = 1'b1;
    tick(1);
    tp_ready = 1'b0;
    checks++; if (tp_level !== 2'd2) begin failures++; $display("FAIL bp_pushpop_level got=%0d exp=2", tp_level); end
    checks++; if (tp_cnt !== 32'd3)  begin failures++; $display("FAIL bp_cnt3 got=%0d exp=3", tp_cnt); end
    checks++; if (tp_data !== 4'h5)  begin failures++; $display("FAIL bp_second got=%h exp=5", tp_data); end
    checks++; if (tp_stall !== 1'b0) begin failures++; $display("FAIL bp_unstall got=%b exp=0", tp_stall); end
    tick(1);
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL bp_ack_d1 got=%b exp=0", tp_ack); end
    tick(1);
    checks++; if (tp_ack !== 1'b1)   begin failures++; $display("FAIL bp_ack_d2 got=%b exp=1", tp_ack); end
    tp_ready = 1'b1;
    tick(1);
    checks++; if (tp_data !== 4'h3)  begin failures++; $display("FAIL bp_third got=%h exp=3", tp_data); end
    checks++; if (tp_level !== 2'd1) begin failures++; $display("FAIL bp_drain1 got=%0d exp=1", tp_level); end
    tick(1);
    tp_ready = 1'b0;
    checks++; if (tp_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", tp_valid); end
  endtask

  task automatic test_proto_err();
    tp_in[0] = ~tp_in[0];
    tick(3);
    checks++; if (tp_err !== 1'b1)   begin failures++; $display("FAIL perr_set got=%b exp=1", tp_err); end
    tick(4);
    checks++; if (tp_err !== 1'b1)   begin failures++; $display("FAIL perr_sticky got=%b exp=1", tp_err); end
    checks++; if (tp_cnt !== 32'd3)  begin failures++; $display("FAIL perr_cnt got=%0d exp=3", tp_cnt); end
    checks++; if (tp_level !== 2'd0) begin failures++; $display("FAIL perr_level got=%0d exp=0", tp_level); end
    checks++; if (tp_ack !== 1'b1)   begin failures++; $display("FAIL perr_ack got=%b exp=1", tp_ack); end
  endtask

  task automatic test_fp();
    fp_in[1][1] = 1'b1;
    fp_in[0][1] = 1'b1;
    tick(3);
    checks++; if (fp_cnt !== 32'd1)  begin failures++; $display("FAIL fp_cnt1 got=%0d exp=1", fp_cnt); end
    checks++; if (fp_data !== 2'b11) begin failures++; $display("FAIL fp_data1 got=%b exp=11", fp_data); end
    tick(1);
    checks++; if (fp_ack !== 1'b0)   begin failures++; $display("FAIL fp_ack_d1 got=%b exp=0", fp_ack); end
    tick(1);
    checks++; if (fp_ack !== 1'b1)   begin failures++; $display("FAIL fp_ack_rise got=%b exp=1", fp_ack); end
    tick(2);
    checks++; if (fp_cnt !== 32'd1)  begin failures++; $display("FAIL fp_hold_cnt got=%0d exp=1", fp_cnt); end
    fp_in = '0;
    tick(4);
    checks++; if (fp_ack !== 1'b1)   begin failures++; $display("FAIL fp_rtz_d1 got=%b exp=1", fp_ack); end
    tick(1);
    checks++; if (fp_ack !== 1'b0)   begin failures++; $display("FAIL fp_ack_fall got=%b exp=0", fp_ack); end
    fp_in[1][1] = 1'b1;
    fp_in[0][0] = 1'b1;
    tick(3);
    checks++; if (fp_cnt !== 32'd2)  begin failures++; $display("FAIL fp_cnt2 got=%0d exp=2", fp_cnt); end
    checks++; if (fp_level !== 3'd2) begin failures++; $display("FAIL fp_level2 got=%0d exp=2", fp_level); end
    checks++; if (fp_data !== 2'b11) begin failures++; $display("FAIL fp_head got=%b exp=11", fp_data); end
    tick(2);
    checks++; if (fp_ack !== 1'b1)   begin failures++; $display("FAIL fp_ack2 got=%b exp=1", fp_ack); end
    fp_in = '0;
    tick(5);
    checks++; if (fp_ack !== 1'b0)   begin failures++; $display("FAIL fp_ack2_fall got=%b exp=0", fp_ack); end
    fp_ready = 1'b1;
    tick(1);
    fp_ready = 1'b0;
    checks++; if (fp_data !== 2'b10) begin failures++; $display("FAIL fp_data2 got=%b exp=10", fp_data); end
    checks++; if (fp_err !== 1'b0)   begin failures++; $display("FAIL fp_no_err got=%b exp=0", fp_err); end
  endtask

  task automatic test_reset_mid_delay();
    do_reset();
    checks++; if (tp_err !== 1'b0)   begin failures++; $display("FAIL mrst_err_clr got=%b exp=0", tp_err); end
    send_tp(4'hA);
    tick(3);
    checks++; if (tp_cnt !== 32'd1)  begin failures++; $display("FAIL mrst_cap got=%0d exp=1", tp_cnt); end
    rst   = 1'b0;
    tp_in = '0;
    tick(1);
    rst = 1'b1;
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL mrst_ack got=%b exp=0", tp_ack); end
    checks++; if (tp_level !== 2'd0) begin failures++; $display("FAIL mrst_level got=%0d exp=0", tp_level); end
    checks++; if (tp_cnt !== 32'd0)  begin failures++; $display("FAIL mrst_cnt got=%0d exp=0", tp_cnt); end
    tick(4);
    checks++; if (tp_ack !== 1'b0)   begin failures++; $display("FAIL mrst_no_pending got=%b exp=0", tp_ack); end
    send_tp(4'h5);
    tick(3);
    checks++; if (tp_cnt !== 32'd1)  begin failures++; $display("FAIL mrst_recap got=%0d exp=1", tp_cnt); end
    checks++; if (tp_data !== 4'h5)  begin failures++; $display("FAIL mrst_data got=%h exp=5", tp_data); end
    tick(2);
    checks++; if (tp_ack !== 1'b1)   begin failures++; $display("FAIL mrst_ack_after got=%b exp=1", tp_ack); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    tp_in    = '0;
    fp_in    = '0;
    tp_ready = 1'b0;
    fp_ready = 1'b0;
    test_reset();
    test_tp_words();
    test_back_to_back();
    test_proto_err();
    test_fp();
    test_reset_mid_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
